// File: rtl/risc_multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath/memory port.
// The controller uses the master modport; the datapath side uses the slave modport.
interface risc_multicycle_controller_if;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        zero;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_write;
    logic        adr_src;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_op;
    logic [1:0]  imm_src;
    logic [1:0]  result_src;
    logic        instr_done;
    logic        illegal;
    logic [31:0] cycle_count;
    logic [31:0] instret;

    modport master (
        input  opcode, funct3, funct7, zero, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_op, imm_src, result_src,
               instr_done, illegal, cycle_count, instret
    );

    modport slave (
        output opcode, funct3, funct7, zero, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_op, imm_src, result_src,
               instr_done, illegal, cycle_count, instret
    );
endinterface

// File: rtl/risc_multicycle_controller.sv
// Moore FSM sequencing an RV32I-subset shared-memory datapath; arbitrates the memory port via req/ready.
// RISC_MC_PERF_EN builds the cycle_count/instret counters; otherwise both ports are tied to 0.
module risc_multicycle_controller (
    input  logic                          clk,
    input  logic                          rst,
    risc_multicycle_controller_if.master  bus
);
    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECR    = 4'd6;
    localparam logic [3:0] EXECI    = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] BRANCH   = 4'd9;
    localparam logic [3:0] JAL      = 4'd10;
    localparam logic [3:0] TRAP     = 4'd11;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [3:0] state, state_nxt;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic       instr_done, illegal;
    logic [1:0] alu_src_a, alu_src_b, imm_src, result_src;
    logic [2:0] alu_op;

    function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub_en);
        case (f3)
            3'b000:  return sub_en ? 3'b001 : 3'b000;
            3'b111:  return 3'b010;
            3'b110:  return 3'b011;
            3'b001:  return 3'b100;
            3'b101:  return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 3'b000;
        imm_src    = 2'b00;
        result_src = 2'b00;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state)
            FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = bus.mem_ready;
                pc_write   = bus.mem_ready;
                if (bus.mem_ready) state_nxt = DECODE;
            end
            DECODE: begin
                // Branch target precomputed into ALU-out while the opcode is dispatched.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 2'b10;
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_nxt = MEMADR;
                    OP_RTYPE:          state_nxt = EXECR;
                    OP_ITYPE:          state_nxt = EXECI;
                    OP_BRANCH:         state_nxt = BRANCH;
                    OP_JAL:            state_nxt = JAL;
                    default:           state_nxt = TRAP;
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = (bus.opcode == OP_STORE) ? 2'b01 : 2'b00;
                state_nxt = (bus.opcode == OP_STORE) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (bus.mem_ready) state_nxt = MEMWB;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                result_src = 2'b01;
                instr_done = 1'b1;
                state_nxt  = FETCH;
            end
            MEMWRITE: begin
                mem_req    = 1'b1;
                mem_write  = 1'b1;
                adr_src    = 1'b1;
                instr_done = bus.mem_ready;
                if (bus.mem_ready) state_nxt = FETCH;
            end
            EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = alu_decode(bus.funct3, bus.funct7 == 7'b0100000);
                state_nxt = ALUWB;
            end
            EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = alu_decode(bus.funct3, 1'b0);
                state_nxt = ALUWB;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_nxt  = FETCH;
            end
            BRANCH: begin
                alu_src_a  = 2'b10;
                alu_op     = 3'b001;
                pc_write   = (bus.funct3 == 3'b000) ? bus.zero : !bus.zero;
                instr_done = 1'b1;
                state_nxt  = FETCH;
            end
            JAL: begin
                // PC takes the target from ALU-out; link value old-PC+4 goes to ALU-out for ALUWB.
                pc_write  = 1'b1;
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                state_nxt = ALUWB;
            end
            TRAP: begin
                illegal = 1'b1;
            end
            default: state_nxt = FETCH;
        endcase
    end

    // Outputs are forced low during reset so strobes drop without waiting for a clock.
    assign bus.mem_req    = rst ? 1'b0  : mem_req;
    assign bus.mem_write  = rst ? 1'b0  : mem_write;
    assign bus.adr_src    = rst ? 1'b0  : adr_src;
    assign bus.ir_write   = rst ? 1'b0  : ir_write;
    assign bus.pc_write   = rst ? 1'b0  : pc_write;
    assign bus.reg_write  = rst ? 1'b0  : reg_write;
    assign bus.alu_src_a  = rst ? 2'b00 : alu_src_a;
    assign bus.alu_src_b  = rst ? 2'b00 : alu_src_b;
    assign bus.alu_op     = rst ? 3'b000 : alu_op;
    assign bus.imm_src    = rst ? 2'b00 : imm_src;
    assign bus.result_src = rst ? 2'b00 : result_src;
    assign bus.instr_done = rst ? 1'b0  : instr_done;
    assign bus.illegal    = rst ? 1'b0  : illegal;

`ifdef RISC_MC_PERF_EN
    logic [31:0] cycle_q, instret_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q   <= 32'd0;
            instret_q <= 32'd0;
        end else begin
            if (state != TRAP) cycle_q   <= cycle_q + 32'd1;
            if (instr_done)    instret_q <= instret_q + 32'd1;
        end
    end

    assign bus.cycle_count = cycle_q;
    assign bus.instret     = instret_q;
`else
    assign bus.cycle_count = 32'd0;
    assign bus.instret     = 32'd0;
`endif
endmodule

// File: tb/tb_risc_multicycle_controller.sv
// Directed-vector bench for risc_multicycle_controller; counter checks adapt to RISC_MC_PERF_EN.
module tb_risc_multicycle_controller;
`ifdef RISC_MC_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    risc_multicycle_controller_if bus ();
    risc_multicycle_controller dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Field order: mem_req mem_write adr_src ir_write pc_write reg_write a b op imm res done illegal
    function automatic logic [18:0] pk(input logic mr, input logic mw, input logic ad,
                                       input logic iw, input logic pw, input logic rw,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [2:0] op, input logic [1:0] imm,
                                       input logic [1:0] res, input logic dn, input logic il);
        return {mr, mw, ad, iw, pw, rw, a, b, op, imm, res, dn, il};
    endfunction

    function automatic logic [18:0] obs();
        return {bus.mem_req, bus.mem_write, bus.adr_src, bus.ir_write, bus.pc_write,
                bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.imm_src,
                bus.result_src, bus.instr_done, bus.illegal};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic rdy, input logic z, input logic [18:0] exp);
        bus.mem_ready = rdy;
        bus.zero      = z;
        #1;
        check(tag, {13'd0, obs()}, {13'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        bus.opcode = op;
        bus.funct3 = f3;
        bus.funct7 = f7;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_outs", {13'd0, obs()}, 32'd0);
        check("rst_cycle", bus.cycle_count, 32'd0);
        check("rst_instret", bus.instret, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [18:0] e_fetch, e_fwait, e_dec, e_madr_lw, e_madr_sw, e_mrd, e_mwb;
    logic [18:0] e_mwr, e_mwr_wait, e_execr_add, e_execr_sub, e_aluwb, e_br_t, e_br_n, e_jal, e_trap;

    initial begin
        e_fetch     = pk(1,0,0,1,1,0, 2'b00,2'b10,3'b000,2'b00,2'b10, 0,0);
        e_fwait     = pk(1,0,0,0,0,0, 2'b00,2'b10,3'b000,2'b00,2'b10, 0,0);
        e_dec       = pk(0,0,0,0,0,0, 2'b01,2'b01,3'b000,2'b10,2'b00, 0,0);
        e_madr_lw   = pk(0,0,0,0,0,0, 2'b10,2'b01,3'b000,2'b00,2'b00, 0,0);
        e_madr_sw   = pk(0,0,0,0,0,0, 2'b10,2'b01,3'b000,2'b01,2'b00, 0,0);
        e_mrd       = pk(1,0,1,0,0,0, 2'b00,2'b00,3'b000,2'b00,2'b00, 0,0);
        e_mwb       = pk(0,0,0,0,0,1, 2'b00,2'b00,3'b000,2'b00,2'b01, 1,0);
        e_mwr       = pk(1,1,1,0,0,0, 2'b00,2'b00,3'b000,2'b00,2'b00, 1,0);
        e_mwr_wait  = pk(1,1,1,0,0,0, 2'b00,2'b00,3'b000,2'b00,2'b00, 0,0);
        e_execr_add = pk(0,0,0,0,0,0, 2'b10,2'b00,3'b000,2'b00,2'b00, 0,0);
        e_execr_sub = pk(0,0,0,0,0,0, 2'b10,2'b00,3'b001,2'b00,2'b00, 0,0);
        e_aluwb     = pk(0,0,0,0,0,1, 2'b00,2'b00,3'b000,2'b00,2'b00, 1,0);
        e_br_t      = pk(0,0,0,0,1,0, 2'b10,2'b00,3'b001,2'b00,2'b00, 1,0);
        e_br_n      = pk(0,0,0,0,0,0, 2'b10,2'b00,3'b001,2'b00,2'b00, 1,0);
        e_jal       = pk(0,0,0,0,1,0, 2'b01,2'b10,3'b000,2'b00,2'b00, 0,0);
        e_trap      = pk(0,0,0,0,0,0, 2'b00,2'b00,3'b000,2'b00,2'b00, 0,1);

        bus.mem_ready = 1'b1;
        bus.zero      = 1'b0;
        set_instr(7'b0110011, 3'b000, 7'b0000000);
        #2;
        check("por_outs", {13'd0, obs()}, 32'd0);
        do_reset();

        // add x3,x1,x2 at zero wait
        cyc("add_fetch", 1, 0, e_fetch);
        cyc("add_decode", 1, 0, e_dec);
        cyc("add_execr", 1, 0, e_execr_add);
        cyc("add_aluwb", 1, 0, e_aluwb);

        // lw with two wait cycles in FETCH and MEMREAD
        set_instr(7'b0000011, 3'b010, 7'b0000000);
        cyc("lw_fwait0", 0, 0, e_fwait);
        cyc("lw_fwait1", 0, 0, e_fwait);
        cyc("lw_fetch", 1, 0, e_fetch);
        cyc("lw_decode", 0, 0, e_dec);
        cyc("lw_memadr", 0, 0, e_madr_lw);
        cyc("lw_rwait0", 0, 0, e_mrd);
        cyc("lw_rwait1", 0, 0, e_mrd);
        cyc("lw_memread", 1, 0, e_mrd);
        cyc("lw_memwb", 0, 0, e_mwb);

        // beq taken, bne not taken, bne taken
        set_instr(7'b1100011, 3'b000, 7'b0000000);
        cyc("beq_fetch", 1, 1, e_fetch);
        cyc("beq_decode", 1, 1, e_dec);
        cyc("beq_branch", 1, 1, e_br_t);
        set_instr(7'b1100011, 3'b001, 7'b0000000);
        cyc("bne_fetch", 1, 1, e_fetch);
        cyc("bne_decode", 1, 1, e_dec);
        cyc("bne_z1_branch", 1, 1, e_br_n);
        cyc("bne2_fetch", 1, 0, e_fetch);
        cyc("bne2_decode", 1, 0, e_dec);
        cyc("bne_z0_branch", 1, 0, e_br_t);

        // sub, addi with funct7 set, and the other funct3 mappings
        set_instr(7'b0110011, 3'b000, 7'b0100000);
        cyc("sub_fetch", 1, 0, e_fetch);
        cyc("sub_decode", 1, 0, e_dec);
        cyc("sub_execr", 1, 0, e_execr_sub);
        cyc("sub_aluwb", 1, 0, e_aluwb);
        set_instr(7'b0010011, 3'b000, 7'b0100000);
        cyc("addi_fetch", 1, 0, e_fetch);
        cyc("addi_decode", 1, 0, e_dec);
        cyc("addi_execi", 1, 0, pk(0,0,0,0,0,0, 2'b10,2'b01,3'b000,2'b00,2'b00, 0,0));
        cyc("addi_aluwb", 1, 0, e_aluwb);
        set_instr(7'b0110011, 3'b111, 7'b0000000);
        cyc("and_fetch", 1, 0, e_fetch);
        cyc("and_decode", 1, 0, e_dec);
        cyc("and_execr", 1, 0, pk(0,0,0,0,0,0, 2'b10,2'b00,3'b010,2'b00,2'b00, 0,0));
        cyc("and_aluwb", 1, 0, e_aluwb);
        set_instr(7'b0010011, 3'b110, 7'b0000000);
        cyc("ori_fetch", 1, 0, e_fetch);
        cyc("ori_decode", 1, 0, e_dec);
        cyc("ori_execi", 1, 0, pk(0,0,0,0,0,0, 2'b10,2'b01,3'b011,2'b00,2'b00, 0,0));
        cyc("ori_aluwb", 1, 0, e_aluwb);
        set_instr(7'b0110011, 3'b001, 7'b0000000);
        cyc("sll_fetch", 1, 0, e_fetch);
        cyc("sll_decode", 1, 0, e_dec);
        cyc("sll_execr", 1, 0, pk(0,0,0,0,0,0, 2'b10,2'b00,3'b100,2'b00,2'b00, 0,0));
        cyc("sll_aluwb", 1, 0, e_aluwb);
        set_instr(7'b0010011, 3'b101, 7'b0000000);
        cyc("srli_fetch", 1, 0, e_fetch);
        cyc("srli_decode", 1, 0, e_dec);
        cyc("srli_execi", 1, 0, pk(0,0,0,0,0,0, 2'b10,2'b01,3'b101,2'b00,2'b00, 0,0));
        cyc("srli_aluwb", 1, 0, e_aluwb);
        set_instr(7'b0110011, 3'b010, 7'b0100000);
        cyc("slt_fetch", 1, 0, e_fetch);
        cyc("slt_decode", 1, 0, e_dec);
        cyc("slt_execr_add", 1, 0, e_execr_add);
        cyc("slt_aluwb", 1, 0, e_aluwb);

        // sw with one wait, then jal
        set_instr(7'b0100011, 3'b010, 7'b0000000);
        cyc("sw_fetch", 1, 0, e_fetch);
        cyc("sw_decode", 1, 0, e_dec);
        cyc("sw_memadr", 1, 0, e_madr_sw);
        cyc("sw_wwait", 0, 0, e_mwr_wait);
        cyc("sw_memwrite", 1, 0, e_mwr);
        set_instr(7'b1101111, 3'b000, 7'b0000000);
        cyc("jal_fetch", 1, 0, e_fetch);
        cyc("jal_decode", 1, 0, e_dec);
        cyc("jal_jal", 1, 0, e_jal);
        cyc("jal_aluwb", 1, 0, e_aluwb);

        // illegal opcode: TRAP is absorbing, reset recovers
        do_reset();
        set_instr(7'b1110011, 3'b000, 7'b0000000);
        cyc("trap_fetch", 1, 0, e_fetch);
        cyc("trap_decode", 1, 0, e_dec);
        for (int i = 0; i < 4; i++) cyc($sformatf("trap_hold%0d", i), i[0], 0, e_trap);
        check("trap_cycle_halt", bus.cycle_count, PERF ? 32'd2 : 32'd0);
        check("trap_instret", bus.instret, 32'd0);
        do_reset();
        set_instr(7'b0110011, 3'b000, 7'b0000000);
        cyc("post_trap_fetch", 1, 0, e_fetch);

        // 10 back-to-back R-type at zero wait
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc("b2b_fetch", 1, 0, e_fetch);
            cyc("b2b_decode", 1, 0, e_dec);
            cyc("b2b_execr", 1, 0, e_execr_add);
            cyc("b2b_aluwb", 1, 0, e_aluwb);
        end
        check("b2b_cycle_count", bus.cycle_count, PERF ? 32'd40 : 32'd0);
        check("b2b_instret", bus.instret, PERF ? 32'd10 : 32'd0);

        // reset while a store is waiting on memory
        do_reset();
        set_instr(7'b0100011, 3'b010, 7'b0000000);
        cyc("rsw_fetch", 1, 0, e_fetch);
        cyc("rsw_decode", 1, 0, e_dec);
        cyc("rsw_memadr", 1, 0, e_madr_sw);
        bus.mem_ready = 1'b0;
        #1;
        check("rsw_mem_write_hi", {31'd0, bus.mem_write}, 32'd1);
        check("rsw_cycle_pre", bus.cycle_count, PERF ? 32'd3 : 32'd0);
        rst = 1'b1;
        #1;
        check("rsw_mem_write_drop", {31'd0, bus.mem_write}, 32'd0);
        check("rsw_outs_zero", {13'd0, obs()}, 32'd0);
        check("rsw_cycle_clr", bus.cycle_count, 32'd0);
        check("rsw_instret_clr", bus.instret, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        cyc("rsw_restart_fetch", 1, 0, e_fetch);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/risc_multicycle_controller.md
# risc_multicycle_controller

Multi-cycle sequencing controller for the RV32I subset datapath: lw, sw, R-type, I-type ALU, beq/bne, jal. It replaces single-cycle combinational decode with a Moore FSM that steps a shared-memory datapath (one ALU, one memory port, IR/old-PC/ALU-out registers) through fetch, decode, execute, memory and writeback. It also arbitrates that memory port between instruction fetch and data access through a req/ready handshake.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7  in  7  IR[31:25]
- zero  in  1  ALU zero flag, current cycle
- mem_ready  in  1  memory completes the access this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  request is a store (qualifies mem_req)
- adr_src  out  1  0=PC, 1=ALU-out register
- ir_write  out  1  load IR and old-PC
- pc_write  out  1  load PC from result mux
- reg_write  out  1  register file write
- alu_src_a  out  2  00=PC, 01=old-PC, 10=rs1
- alu_src_b  out  2  00=rs2, 01=imm, 10=constant 4
- alu_op  out  3  000 add, 001 sub, 010 and, 011 or, 100 sll, 101 srl
- imm_src  out  2  00 I, 01 S, 10 B, 11 J
- result_src  out  2  00=ALU-out register, 01=memory data register, 10=ALU result
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction
- illegal  out  1  sticky: unsupported opcode decoded
- cycle_count  out  32  see Configuration
- instret  out  32  see Configuration

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP.
- FETCH: mem_req=1, adr_src=0, ALU computes PC+4 (a=00, b=10, add, result_src=10). If mem_ready=1, pulse ir_write and pc_write, then go to DECODE. Otherwise hold.
- DECODE: ALU computes old-PC+imm (a=01, b=01, imm_src=10). The result lands in ALU-out and is used as the branch target. Dispatch on opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - anything else -> TRAP
- MEMADR: rs1+imm (a=10, b=01). imm_src=00 for lw, 01 for sw. Go to MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: mem_req=1, adr_src=1. Go to MEMWB when mem_ready=1.
- MEMWB: reg_write=1, result_src=01, instr_done=1, then FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1. When mem_ready=1: instr_done=1, then FETCH.
- EXECR: a=10, b=00. alu_op decoded from funct3: 000 add (sub if funct7=0100000), 111 and, 110 or, 001 sll, 101 srl. Go to ALUWB.
- EXECI: a=10, b=01, imm_src=00. Same funct3 map, but funct7 is ignored for 000 (always add). Go to ALUWB.
- Any unlisted funct3 decodes to add.
- ALUWB: reg_write=1, result_src=00, instr_done=1, then FETCH.
- BRANCH: a=10, b=00, sub. pc_write=1 with result_src=00 when (funct3=000 and zero) or (funct3≠000 and !zero). instr_done=1, then FETCH.
- JAL: pc_write=1, result_src=00 (target). ALU computes old-PC+4 (a=01, b=10) into ALU-out. Go to ALUWB.
- TRAP: absorbing. illegal=1, all strobes 0. Exit only by reset.
- Unlisted outputs are 0 in every state (don't-care muxes drive 0).

## Timing
- Moore outputs, decoded from state. Exceptions:
  - FETCH ir_write/pc_write are gated by mem_ready.
  - BRANCH pc_write is gated by zero.
  - MEMWRITE instr_done is gated by mem_ready.
- Zero-wait latency:
  - lw 5 cycles
  - sw, R-type, I-type, jal 4 cycles
  - branch 3 cycles
- Each mem_ready=0 cycle adds one cycle.
- mem_req, adr_src and mem_write are stable while waiting. mem_ready is ignored when mem_req=0.
- Reset:
  - While rst=1, state=FETCH and every output is forced to 0, including mem_req, illegal and both counters.
  - The first cycle after deassertion is FETCH with mem_req=1.
  - Reset mid-instruction abandons it. mem_write and reg_write drop asynchronously.

## Configuration
- RISC_MC_PERF_EN defined:
  - cycle_count increments every cycle out of reset. It halts in TRAP.
  - instret increments on every instr_done.
  - Both wrap 0xFFFFFFFF -> 0.
- RISC_MC_PERF_EN undefined: both ports are tied to 0 and no counter flops are built.

## Test plan
- Reset then add x3,x1,x2 (opcode 0110011, funct3 000, funct7 0), mem_ready tied 1 -> FETCH, DECODE, EXECR, ALUWB. alu_op=000 in EXECR. reg_write=1 and instr_done=1 on cycle 4.
- lw with mem_ready low for 2 cycles in both FETCH and MEMREAD -> 9 cycles total. mem_req and adr_src hold steady through each wait. reg_write with result_src=01 in the final cycle.
- beq with zero=1, then bne with zero=1 -> pc_write=1 in BRANCH for beq. pc_write=0 for bne. Both take 3 cycles.
- sub (funct7=0100000) -> alu_op=001. addi with funct7 bits=0100000 -> alu_op=000.
- opcode 1110011 -> TRAP after DECODE. illegal=1 and mem_req=0 indefinitely. Asserting rst clears illegal and restarts FETCH.
- With RISC_MC_PERF_EN: 10 back-to-back R-type at zero wait -> cycle_count=40, instret=10. Reset mid-MEMWRITE -> mem_write falls immediately and both counters read 0.
